// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_pkg
//  Purpose  : Shared encodings for the EX-stage multiply/divide unit:
//             operation codes, forwarding selects and FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package ex_muldiv_pkg;

   // Operation codes presented on op
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   // Operand forwarding selects, identical to the forwarding unit's output
   localparam logic [1:0] FWD_IDEX  = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_FIN  = 2'b10;

endpackage : ex_muldiv_pkg
`default_nettype wire

// File: rtl/ex_muldiv_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : 3-input operand mux driven by a forwarding select; 2'b11
//             falls back to the ID/EX register value.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_mux
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       sel_i,
   input  logic [WIDTH-1:0] idex_i,
   input  logic [WIDTH-1:0] wb_i,
   input  logic [WIDTH-1:0] exmem_i,
   output logic [WIDTH-1:0] data_o
);

   // Pick the freshest copy of the operand
   always_comb begin
      case (sel_i)
         FWD_EXMEM: data_o = exmem_i;
         FWD_WB:    data_o = wb_i;
         default:   data_o = idex_i;
      endcase
   end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Iterative radix-2 MULT/MULTU/DIV/DIVU unit writing HI/LO,
//             with MTHI/MTLO and a pipeline stall for dependent requests.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             mf_req,
   input  logic             kill,
   input  logic [1:0]       forwardA,
   input  logic [1:0]       forwardB,
   input  logic [WIDTH-1:0] id2ex_rs_data,
   input  logic [WIDTH-1:0] id2ex_rt_data,
   input  logic [WIDTH-1:0] ex2mem_alu_out,
   input  logic [WIDTH-1:0] wb_data,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q, sgn_res_q, sgn_rem_q, dz_q;
   logic [WIDTH-1:0]   a_raw_q, opb_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc_q;   // multiply: {partial, multiplier}; divide: low half = dividend/quotient
   logic [WIDTH:0]     rem_q;

   logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
   logic               w_accept, w_start_md, w_signed, w_a_neg, w_b_neg, w_last;
   logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem;

   fwd_mux #(.WIDTH(WIDTH)) u_mux_a (
      .sel_i(forwardA), .idex_i(id2ex_rs_data), .wb_i(wb_data),
      .exmem_i(ex2mem_alu_out), .data_o(w_a));

   fwd_mux #(.WIDTH(WIDTH)) u_mux_b (
      .sel_i(forwardB), .idex_i(id2ex_rt_data), .wb_i(wb_data),
      .exmem_i(ex2mem_alu_out), .data_o(w_b));

   // Operand conditioning and per-step arithmetic
   always_comb begin
      w_accept    = (state_q == ST_IDLE) && start && !kill;
      w_start_md  = w_accept && !op[2];
      w_signed    = (op == OP_MULT) || (op == OP_DIV);
      w_a_neg     = w_signed && w_a[WIDTH-1];
      w_b_neg     = w_signed && w_b[WIDTH-1];
      w_a_mag     = w_a_neg ? (WIDTH'(0) - w_a) : w_a;
      w_b_mag     = w_b_neg ? (WIDTH'(0) - w_b) : w_b;
      w_last      = (cnt_q == CW'(WIDTH - 1));
      w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      // Remainder stays below the divisor, so the difference fits WIDTH+1 bits and its MSB is the sign
      w_div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, opb_q};
      w_prod      = sgn_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
      w_quo       = sgn_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      w_rem       = sgn_rem_q ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: WIDTH RUN steps, one FIN cycle, kill aborts to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_start_md) state_d = ST_RUN;
         ST_RUN:  if (kill) state_d = ST_IDLE;
                  else if (w_last) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: stall holds any new request while an operation is in flight
   always_comb begin
      busy  = (state_q != ST_IDLE);
      stall = busy && (start || mf_req);
      hi    = hi_q;
      lo    = lo_q;
   end

   // Datapath: operand capture, iteration and HI/LO write-back
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         sgn_res_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         a_raw_q   <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_start_md) begin
                  cnt_q     <= '0;
                  is_div_q  <= op[1];
                  sgn_res_q <= w_a_neg ^ w_b_neg;
                  sgn_rem_q <= w_a_neg;
                  dz_q      <= op[1] && (w_b == '0);
                  a_raw_q   <= w_a;
                  opb_q     <= w_b_mag;
                  acc_q     <= {{WIDTH{1'b0}}, w_a_mag};
                  rem_q     <= '0;
               end else if (w_accept && op == OP_MTHI) begin
                  hi_q <= w_a;
               end else if (w_accept && op == OP_MTLO) begin
                  lo_q <= w_a;
               end
            end
            ST_RUN: begin
               if (!kill) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (is_div_q) begin
                     rem_q <= w_div_diff[WIDTH] ? w_div_shift : w_div_diff;
                     acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
                  end else begin
                     acc_q <= {w_mul_sum, acc_q[WIDTH-1:1]};
                  end
               end
            end
            ST_FIN: begin
               if (!kill) begin
                  if (!is_div_q) begin
                     hi_q <= w_prod[2*WIDTH-1:WIDTH];
                     lo_q <= w_prod[WIDTH-1:0];
                  end else if (dz_q) begin
                     hi_q <= a_raw_q;
                     lo_q <= '1;
                  end else begin
                     hi_q <= w_rem;
                     lo_q <= w_quo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule : ex_muldiv
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking bench for ex_muldiv: directed cases plus random
//             operations compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, mf_req, kill;
   logic [2:0]   op;
   logic [1:0]   forwardA, forwardB;
   logic [W-1:0] id2ex_rs_data, id2ex_rt_data, ex2mem_alu_out, wb_data;
   logic         busy, stall;
   logic [W-1:0] hi, lo;

   int           total = 0;
   int           bad   = 0;
   logic [31:0]  exp_hi = '0;
   logic [31:0]  exp_lo = '0;

   ex_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .mf_req(mf_req),
      .kill(kill), .forwardA(forwardA), .forwardB(forwardB),
      .id2ex_rs_data(id2ex_rs_data), .id2ex_rt_data(id2ex_rt_data),
      .ex2mem_alu_out(ex2mem_alu_out), .wb_data(wb_data),
      .busy(busy), .stall(stall), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural HI/LO effect of one accepted instruction
   function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] h, inout logic [31:0] l);
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         OP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         OP_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF;
            end else if (o == OP_DIV) begin
               q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
            end else begin
               uq = ua / ub; ur = ua % ub; h = ur[31:0]; l = uq[31:0];
            end
         end
         OP_MTHI:  h = a;
         OP_MTLO:  l = a;
         default:  ;
      endcase
   endfunction

   // Place A and B on whichever sources the selects name; the rest get noise
   task automatic drive_ops(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b);
      id2ex_rs_data  = $urandom;
      id2ex_rt_data  = $urandom;
      ex2mem_alu_out = $urandom;
      wb_data        = $urandom;
      forwardA       = fa;
      forwardB       = fb;
      case (fa)
         2'b10:   ex2mem_alu_out = a;
         2'b01:   wb_data = a;
         default: id2ex_rs_data = a;
      endcase
      case (fb)
         2'b10:   ex2mem_alu_out = b;
         2'b01:   wb_data = b;
         default: id2ex_rt_data = b;
      endcase
   endtask

   // Issue one instruction, follow it to completion and check HI/LO and latency
   task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] a, input logic [31:0] b, input bit hold_mf);
      int n;
      @(negedge clk);
      drive_ops(fa, fb, a, b);
      op     = o;
      start  = 1'b1;
      mf_req = hold_mf;
      @(negedge clk);
      start = 1'b0;
      ref_model(o, a, b, exp_hi, exp_lo);
      if (o[2]) begin
         check_val({tag, " busy"}, {31'b0, busy}, 32'd0);
      end else begin
         n = 0;
         while (busy && n < 64) begin
            n++;
            if (hold_mf) check_val({tag, " stall"}, {31'b0, stall}, 32'd1);
            @(negedge clk);
         end
         check_val({tag, " cycles"}, n, 32'd33);
         if (hold_mf) check_val({tag, " stall_end"}, {31'b0, stall}, 32'd0);
      end
      mf_req = 1'b0;
      check_val({tag, " hi"}, hi, exp_hi);
      check_val({tag, " lo"}, lo, exp_lo);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [2:0]  ro;
      logic [1:0]  rfa, rfb;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b1; mf_req = 1'b1; kill = 1'b0; op = OP_MULT;
      drive_ops(2'b00, 2'b00, 32'd5, 32'd6);
      repeat (2) @(negedge clk);
      check_val("reset busy", {31'b0, busy}, 32'd0);
      check_val("reset stall", {31'b0, stall}, 32'd0);
      check_val("reset hi", hi, 32'd0);
      check_val("reset lo", lo, 32'd0);
      reset = 1'b0; start = 1'b0; mf_req = 1'b0;

      run_op("mult_neg", OP_MULT, 2'b00, 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
      run_op("div_exmem", OP_DIV, 2'b10, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("divu_zero", OP_DIVU, 2'b00, 2'b01, 32'd100, 32'd0, 1'b0);
      run_op("multu_max", OP_MULTU, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf", OP_DIV, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("div_zero_neg", OP_DIV, 2'b01, 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

      // start held during busy is not accepted until the first IDLE cycle
      @(negedge clk);
      drive_ops(2'b00, 2'b00, 32'd5, 32'd6);
      op = OP_MULT; start = 1'b1;
      @(negedge clk);
      op = OP_MTHI; id2ex_rs_data = 32'h0000_CAFE; forwardA = FWD_IDEX;
      n = 0;
      while (busy && n < 64) begin
         n++;
         check_val("hold stall", {31'b0, stall}, 32'd1);
         @(negedge clk);
      end
      check_val("hold cycles", n, 32'd33);
      check_val("hold stall_end", {31'b0, stall}, 32'd0);
      check_val("hold lo", lo, 32'd30);
      check_val("hold hi_pre", hi, 32'd0);
      @(negedge clk);
      start = 1'b0;
      check_val("hold hi_mthi", hi, 32'h0000_CAFE);
      exp_hi = 32'h0000_CAFE; exp_lo = 32'd30;

      // kill during RUN leaves HI/LO untouched
      run_op("mthi", OP_MTHI, 2'b00, 2'b00, 32'h0000_1234, 32'd0, 1'b0);
      run_op("mtlo", OP_MTLO, 2'b00, 2'b00, 32'h0000_5678, 32'd0, 1'b0);
      @(negedge clk);
      drive_ops(2'b00, 2'b00, 32'd100, 32'd7);
      op = OP_DIV; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check_val("kill_run busy", {31'b0, busy}, 32'd0);
      check_val("kill_run hi", hi, 32'h0000_1234);
      check_val("kill_run lo", lo, 32'h0000_5678);
      run_op("mtlo_after", OP_MTLO, 2'b00, 2'b00, 32'h0000_ABCD, 32'd0, 1'b0);

      // kill in the FIN cycle also suppresses the write
      @(negedge clk);
      drive_ops(2'b00, 2'b00, 32'd9, 32'd9);
      op = OP_MULTU; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (32) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check_val("kill_fin busy", {31'b0, busy}, 32'd0);
      check_val("kill_fin lo", lo, exp_lo);

      // reset mid-operation, then start+kill accepts nothing
      @(negedge clk);
      drive_ops(2'b00, 2'b00, 32'd3, 32'd4);
      op = OP_MULT; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("rst_mid busy", {31'b0, busy}, 32'd0);
      check_val("rst_mid hi", hi, 32'd0);
      check_val("rst_mid lo", lo, 32'd0);
      exp_hi = '0; exp_lo = '0;
      start = 1'b1; kill = 1'b1; op = OP_MULT;
      @(negedge clk);
      check_val("startkill busy", {31'b0, busy}, 32'd0);
      op = OP_MTHI; id2ex_rs_data = 32'h55; forwardA = FWD_IDEX;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check_val("startkill hi", hi, 32'd0);

      // random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ro  = 3'($urandom_range(0, 7));
         rfa = 2'($urandom_range(0, 3));
         rfb = 2'($urandom_range(0, 3));
         ra  = pick_val();
         rb  = pick_val();
         if (rfa == rfb && (rfa == 2'b01 || rfa == 2'b10)) rb = ra;
         run_op($sformatf("rand%0d op%0d", i, ro), ro, rfa, rfb, ra, rb, ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ex_muldiv
`default_nettype wire
